mod_counter: RTL and testbench

Parametrised synchronous modulo-N up/down counter for the board-level counter designs. It replaces the per-bit toggle-stage ripple chain: every bit changes on the single system clock, with no derived clocks. It adds a programmable modulus, up/down direction, parallel load, and a terminal-count output for cascading digits. It also has a synchronised, edge-detected push-button step input, so a button can advance the count without being used as a clock.

---
 rtl/mod_counter.sv | 91 +++++++++
 tb/tb_mod_counter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// Synchronous modulo-MODULUS up/down counter with parallel load, terminal count
// and a synchronised, edge-detected push-button step input.
module mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             step,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

  generate
    if (MODULUS < 2 || longint'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_cfg
      $error("mod_counter: MODULUS must lie in 2..2**WIDTH");
    end
  endgenerate

  logic             r_s1, r_s2, r_s3;
  logic [WIDTH-1:0] r_count;
  logic             r_wrap;

  logic             w_step_rise, w_adv;
  logic             w_at_max, w_at_zero;
  logic [WIDTH-1:0] w_inc, w_dec, w_load_clamped;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrap_nxt;

  // s1/s2 resynchronise the button; s3 holds the previous level for edge detect
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= step;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_step_rise = r_s2 & ~r_s3;
  assign w_adv       = en | w_step_rise;

  assign w_at_max  = (r_count == LP_MAX);
  assign w_at_zero = (r_count == '0);

  // Explicit wrap compare keeps the count in range even when MODULUS = 2**WIDTH
  assign w_inc          = w_at_max  ? '0     : r_count + 1'b1;
  assign w_dec          = w_at_zero ? LP_MAX : r_count - 1'b1;
  assign w_load_clamped = (load_val > LP_MAX) ? LP_MAX : load_val;

  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    if (load) begin
      w_count_nxt = w_load_clamped;
    end else if (w_adv) begin
      if (up) begin
        w_count_nxt = w_inc;
        w_wrap_nxt  = w_at_max;
      end else begin
        w_count_nxt = w_dec;
        w_wrap_nxt  = w_at_zero;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;
  assign tc    = up ? w_at_max : w_at_zero;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: vector table for the MODULUS=10 counter plus
// hand sequences for reset/step timing, full-range MODULUS=16 and a two-digit cascade.
module tb_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, step, up, ld;
  logic [3:0] lv;
  logic [3:0] cnt;
  logic       tc, wr;

  logic       en16, up16;
  logic [3:0] lv16, cnt16;
  logic       ld16, tc16, wr16;

  logic       cen;
  logic [3:0] cu_cnt, ct_cnt;
  logic       cu_tc, cu_wr, ct_tc, ct_wr, ct_en;
  logic       nul;
  logic [3:0] nul4;

  mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .reset(rst), .en(en), .step(step), .up(up), .load(ld),
    .load_val(lv), .count(cnt), .tc(tc), .wrap(wr));

  mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .reset(rst), .en(en16), .step(nul), .up(up16), .load(ld16),
    .load_val(lv16), .count(cnt16), .tc(tc16), .wrap(wr16));

  assign ct_en = cen & cu_tc;

  mod_counter #(.WIDTH(4), .MODULUS(10)) u_units (
    .clk(clk), .reset(rst), .en(cen), .step(nul), .up(1'b1), .load(nul),
    .load_val(nul4), .count(cu_cnt), .tc(cu_tc), .wrap(cu_wr));

  mod_counter #(.WIDTH(4), .MODULUS(10)) u_tens (
    .clk(clk), .reset(rst), .en(ct_en), .step(nul), .up(1'b1), .load(nul),
    .load_val(nul4), .count(ct_cnt), .tc(ct_tc), .wrap(ct_wr));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit       rst, en, up, ld;
    bit [3:0] lv;
    bit [3:0] c;
    bit       tc, w;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input bit r, e, u, l, input bit [3:0] v,
                              input bit [3:0] c, input bit t, w);
    vec_t x;
    x.rst = r; x.en = e; x.up = u; x.ld = l; x.lv = v;
    x.c = c; x.tc = t; x.w = w;
    return x;
  endfunction

  initial begin
    int tw, uw;
    rst = 1'b0; en = 1'b1; step = 1'b1; up = 1'b1; ld = 1'b1; lv = 4'd5;
    en16 = 1'b0; up16 = 1'b1; ld16 = 1'b0; lv16 = 4'd0;
    cen = 1'b0; nul = 1'b0; nul4 = 4'd0;

    // reset held two edges against en/load/step
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst.count", cnt, 0);
      chk("rst.wrap", wr, 0);
      chk("rst.tc_up", tc, 0);
    end
    // step still high across release: one advance, third edge with reset high
    rst = 1'b1; en = 1'b0; ld = 1'b0;
    tick(); chk("rel.e1", cnt, 0);
    tick(); chk("rel.e2", cnt, 0);
    tick(); chk("rel.e3", cnt, 1);
    tick(); chk("rel.e4", cnt, 1);
    step = 1'b0;
    rst = 1'b0; up = 1'b0;
    tick();
    chk("rst2.count", cnt, 0);
    chk("rst2.tc_down", tc, 1);
    rst = 1'b1;

    //              rst en up ld lv     cnt   tc w
    vq.push_back(mk(1, 1, 1, 0, 4'd0, 4'd1, 0, 0));
    vq.push_back(mk(1, 1, 1, 0, 4'd0, 4'd2, 0, 0));
    vq.push_back(mk(1, 1, 1, 0, 4'd0, 4'd3, 0, 0));
    vq.push_back(mk(1, 1, 1, 0, 4'd0, 4'd4, 0, 0));
    vq.push_back(mk(1, 1, 1, 0, 4'd0, 4'd5, 0, 0));
    vq.push_back(mk(1, 1, 1, 0, 4'd0, 4'd6, 0, 0));
    vq.push_back(mk(1, 1, 1, 0, 4'd0, 4'd7, 0, 0));
    vq.push_back(mk(1, 1, 1, 0, 4'd0, 4'd8, 0, 0));
    vq.push_back(mk(1, 1, 1, 0, 4'd0, 4'd9, 1, 0));
    vq.push_back(mk(1, 1, 1, 0, 4'd0, 4'd0, 0, 1));
    vq.push_back(mk(1, 1, 1, 0, 4'd0, 4'd1, 0, 0));
    vq.push_back(mk(1, 1, 1, 0, 4'd0, 4'd2, 0, 0));
    // down through zero, then direction switch at 8
    vq.push_back(mk(1, 1, 0, 0, 4'd0, 4'd1, 0, 0));
    vq.push_back(mk(1, 1, 0, 0, 4'd0, 4'd0, 1, 0));
    vq.push_back(mk(1, 1, 0, 0, 4'd0, 4'd9, 0, 1));
    vq.push_back(mk(1, 1, 0, 0, 4'd0, 4'd8, 0, 0));
    vq.push_back(mk(1, 1, 1, 0, 4'd0, 4'd9, 1, 0));
    vq.push_back(mk(1, 1, 1, 0, 4'd0, 4'd0, 0, 1));
    vq.push_back(mk(1, 0, 0, 0, 4'd0, 4'd0, 1, 0));
    // loads: plain, clamped, load beats en, load suppresses wrap
    vq.push_back(mk(1, 0, 1, 1, 4'd7,  4'd7, 0, 0));
    vq.push_back(mk(1, 0, 1, 1, 4'd13, 4'd9, 1, 0));
    vq.push_back(mk(1, 0, 1, 1, 4'd3,  4'd3, 0, 0));
    vq.push_back(mk(1, 1, 1, 1, 4'd5,  4'd5, 0, 0));
    vq.push_back(mk(1, 0, 1, 1, 4'd9,  4'd9, 1, 0));
    vq.push_back(mk(1, 1, 1, 1, 4'd0,  4'd0, 0, 0));
    vq.push_back(mk(1, 0, 1, 1, 4'd15, 4'd9, 1, 0));
    vq.push_back(mk(1, 0, 1, 0, 4'd0,  4'd9, 1, 0));
    vq.push_back(mk(1, 1, 1, 0, 4'd0,  4'd0, 0, 1));
    vq.push_back(mk(1, 0, 1, 0, 4'd0,  4'd0, 0, 0));
    vq.push_back(mk(1, 1, 1, 0, 4'd0,  4'd1, 0, 0));
    // reset mid-run overrides load and en
    vq.push_back(mk(0, 1, 0, 1, 4'd4,  4'd0, 1, 0));

    foreach (vq[i]) begin
      rst = vq[i].rst; en = vq[i].en; up = vq[i].up; ld = vq[i].ld; lv = vq[i].lv;
      tick();
      chk($sformatf("v%0d.count", i), cnt, vq[i].c);
      chk($sformatf("v%0d.tc", i), tc, vq[i].tc);
      chk($sformatf("v%0d.wrap", i), wr, vq[i].w);
    end
    rst = 1'b1; en = 1'b0; up = 1'b1; ld = 1'b0; lv = 4'd0;

    // long press: one advance, visible after the third edge
    step = 1'b1;
    tick(); chk("step.k", cnt, 0);
    tick(); chk("step.k1", cnt, 0);
    tick(); chk("step.k2", cnt, 1);
    for (int i = 0; i < 17; i++) begin
      tick(); chk("step.hold", cnt, 1);
    end
    step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("step.low", cnt, 1);
    end
    // five separate presses
    for (int p = 0; p < 5; p++) begin
      step = 1'b1; tick(); tick();
      step = 1'b0; tick(); tick(); tick();
      chk("press.count", cnt, 2 + p);
    end
    // step rise coincident with en gives a single advance
    step = 1'b1; tick(); tick();
    en = 1'b1; tick();
    chk("coinc.count", cnt, 7);
    en = 1'b0; step = 1'b0;
    tick(); chk("coinc.after1", cnt, 7);
    tick(); chk("coinc.after2", cnt, 7);

    // full binary range: natural overflow must coincide with the wrap
    en16 = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk("m16.count", cnt16, i % 16);
      chk("m16.wrap", wr16, (i == 16) ? 1 : 0);
      chk("m16.tc", tc16, ((i % 16) == 15) ? 1 : 0);
    end
    up16 = 1'b0;
    tick(); chk("m16.dn0", cnt16, 0); chk("m16.dn0_tc", tc16, 1);
    tick(); chk("m16.dn15", cnt16, 15); chk("m16.dn15_wrap", wr16, 1);
    en16 = 1'b0;

    // two-digit cascade from a clean reset
    rst = 1'b0; tick(); rst = 1'b1;
    chk("casc.rst", ct_cnt * 10 + cu_cnt, 0);
    cen = 1'b1; tw = 0; uw = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      chk("casc.units", cu_cnt, i % 10);
      chk("casc.tens", ct_cnt, (i / 10) % 10);
      tw += int'(ct_wr);
      uw += int'(cu_wr);
    end
    cen = 1'b0;
    chk("casc.tens_wraps", tw, 1);
    chk("casc.unit_wraps", uw, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
